// File: rtl/tlp_frag_wide.sv
// tlp_frag_wide: packs IN_DW-wide TLP beats into OUT_DW-wide DLL beats, with a running length check.
// Optional ECRC append is compiled in when TLP_FRAG_ECRC_EN is defined.
module tlp_frag_wide #(
  parameter int unsigned IN_DW  = 4,
  parameter int unsigned OUT_DW = 8
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_DW*32-1:0]          in_data,
  input  logic                         in_sop,
  input  logic                         in_eop,
  input  logic [$clog2(IN_DW+1)-1:0]   in_dw_cnt,
  input  logic [10:0]                  in_length,
  input  logic                         in_td,
  input  logic [31:0]                  ecrc_dw,
  input  logic                         ecrc_valid,
  input  logic                         dll_halt,
  input  logic                         dll_throttle,
  output logic                         out_valid,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [OUT_DW*32-1:0]         out_data,
  output logic [$clog2(OUT_DW+1)-1:0]  out_dw_cnt,
  output logic [10:0]                  out_length,
  output logic                         err_len
);
  localparam int unsigned IW = IN_DW * 32;
  localparam int unsigned AW = OUT_DW * 32;
  localparam int unsigned FW = $clog2(OUT_DW + 1);

`ifdef TLP_FRAG_ECRC_EN
  typedef enum logic [1:0] {IDLE, PACK, ECRC_WAIT} state_t;
  logic td_q, td_n, t0;
`else
  typedef enum logic [1:0] {IDLE, PACK} state_t;
  logic unused_ecrc;
  assign unused_ecrc = ^{in_td, ecrc_dw, ecrc_valid};
`endif

  state_t         state, state_n;
  logic [AW-1:0]  acc, acc_n, merged;
  logic [FW-1:0]  fill, fill_n, f0;
  logic [10:0]    dw_cnt, dw_cnt_n, c0, dw_sum;
  logic [10:0]    len_q, len_n, l0, extra;
  logic           first_q, first_n, fr0;
  logic           in_tlp, take;
  int unsigned    fill_sum;
  logic           emit, emit_sop, emit_eop, err_n;
  logic [AW-1:0]  emit_data;
  logic [FW-1:0]  emit_cnt;
  logic [10:0]    emit_len;

  always_comb begin
    in_ready = 1'b0;
    if (arst && !dll_halt) begin
      case (state)
        IDLE:    in_ready = !dll_throttle;
        PACK:    in_ready = 1'b1;
        default: in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    fill_n    = fill;
    dw_cnt_n  = dw_cnt;
    len_n     = len_q;
    first_n   = first_q;
    emit      = 1'b0;
    emit_data = '0;
    emit_cnt  = '0;
    emit_sop  = 1'b0;
    emit_eop  = 1'b0;
    emit_len  = '0;
    err_n     = 1'b0;

    // A sop beat accepted in IDLE starts from an empty accumulator and its own length.
    in_tlp = (state == PACK);
    f0     = in_tlp ? fill : '0;
    c0     = in_tlp ? dw_cnt : '0;
    l0     = in_tlp ? len_q : in_length;
    fr0    = in_tlp ? first_q : 1'b1;
`ifdef TLP_FRAG_ECRC_EN
    td_n   = td_q;
    t0     = in_tlp ? td_q : in_td;
    extra  = {10'd0, t0};
`else
    extra  = 11'd0;
`endif
    merged = in_tlp ? acc : '0;
    for (int unsigned j = 0; j < IN_DW; j++) begin
      if (j < 32'(in_dw_cnt) && 32'(f0) + j < OUT_DW)
        merged[AW-1-32*(32'(f0)+j) -: 32] = in_data[IW-1-32*j -: 32];
    end
    fill_sum = 32'(f0) + 32'(in_dw_cnt);
    dw_sum   = c0 + 11'(in_dw_cnt);
    take     = in_valid && in_ready && (in_tlp || in_sop);

    if (take) begin
      len_n    = l0;
      dw_cnt_n = dw_sum;
      if (in_eop) begin
        err_n = (in_dw_cnt == '0) || (dw_sum != l0);
`ifdef TLP_FRAG_ECRC_EN
        if (t0) begin
          // A full accumulator goes out now; the ECRC then travels alone in a 1-DW beat.
          state_n = ECRC_WAIT;
          if (fill_sum >= OUT_DW) begin
            emit      = 1'b1;
            emit_data = merged;
            emit_cnt  = FW'(OUT_DW);
            emit_sop  = fr0;
            emit_len  = l0 + 11'd1;
            acc_n     = '0;
            fill_n    = '0;
            first_n   = 1'b0;
          end else begin
            acc_n   = merged;
            fill_n  = FW'(fill_sum);
            first_n = fr0;
          end
        end else
`endif
        begin
          emit      = 1'b1;
          emit_data = merged;
          emit_cnt  = FW'(fill_sum);
          emit_sop  = fr0;
          emit_eop  = 1'b1;
          emit_len  = l0;
          state_n   = IDLE;
          acc_n     = '0;
          fill_n    = '0;
          dw_cnt_n  = '0;
          first_n   = 1'b1;
        end
      end else begin
        state_n = PACK;
`ifdef TLP_FRAG_ECRC_EN
        td_n    = t0;
`endif
        if (fill_sum >= OUT_DW) begin
          emit      = 1'b1;
          emit_data = merged;
          emit_cnt  = FW'(OUT_DW);
          emit_sop  = fr0;
          emit_len  = l0 + extra;
          acc_n     = '0;
          fill_n    = '0;
          first_n   = 1'b0;
        end else begin
          acc_n   = merged;
          fill_n  = FW'(fill_sum);
          first_n = fr0;
        end
      end
    end

`ifdef TLP_FRAG_ECRC_EN
    if (state == ECRC_WAIT && ecrc_valid && !dll_halt) begin
      emit      = 1'b1;
      emit_data = acc;
      emit_data[AW-1-32*32'(fill) -: 32] = ecrc_dw;
      emit_cnt  = FW'(32'(fill) + 1);
      emit_sop  = first_q;
      emit_eop  = 1'b1;
      emit_len  = len_q + 11'd1;
      state_n   = IDLE;
      acc_n     = '0;
      fill_n    = '0;
      dw_cnt_n  = '0;
      first_n   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      state      <= IDLE;
      acc        <= '0;
      fill       <= '0;
      dw_cnt     <= '0;
      len_q      <= '0;
      first_q    <= 1'b1;
`ifdef TLP_FRAG_ECRC_EN
      td_q       <= 1'b0;
`endif
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_data   <= '0;
      out_dw_cnt <= '0;
      out_length <= '0;
      err_len    <= 1'b0;
    end else if (!dll_halt) begin
      state     <= state_n;
      acc       <= acc_n;
      fill      <= fill_n;
      dw_cnt    <= dw_cnt_n;
      len_q     <= len_n;
      first_q   <= first_n;
`ifdef TLP_FRAG_ECRC_EN
      td_q      <= td_n;
`endif
      out_valid <= emit;
      out_sop   <= emit_sop;
      out_eop   <= emit_eop;
      err_len   <= err_n;
      if (emit) begin
        out_data   <= emit_data;
        out_dw_cnt <= emit_cnt;
        out_length <= emit_len;
      end
    end
  end
endmodule

// File: tb/tb_tlp_frag_wide.sv
// tb_tlp_frag_wide: table-driven checks of tlp_frag_wide (IN_DW=4, OUT_DW=8) plus halt/reset/ECRC sequences.
module tb_tlp_frag_wide;
  localparam int unsigned IN_DW  = 4;
  localparam int unsigned OUT_DW = 8;

  logic         clk = 1'b0;
  logic         arst = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [127:0] in_data = '0;
  logic         in_sop = 1'b0, in_eop = 1'b0;
  logic [2:0]   in_dw_cnt = '0;
  logic [10:0]  in_length = '0;
  logic         in_td = 1'b0;
  logic [31:0]  ecrc_dw = '0;
  logic         ecrc_valid = 1'b0;
  logic         dll_halt = 1'b0, dll_throttle = 1'b0;
  logic         out_valid, out_sop, out_eop, err_len;
  logic [255:0] out_data;
  logic [3:0]   out_dw_cnt;
  logic [10:0]  out_length;

  int n_tests = 0;
  int n_fail  = 0;

  tlp_frag_wide #(.IN_DW(IN_DW), .OUT_DW(OUT_DW)) dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop), .in_dw_cnt(in_dw_cnt), .in_length(in_length), .in_td(in_td),
    .ecrc_dw(ecrc_dw), .ecrc_valid(ecrc_valid), .dll_halt(dll_halt), .dll_throttle(dll_throttle),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_data(out_data),
    .out_dw_cnt(out_dw_cnt), .out_length(out_length), .err_len(err_len)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic v, sop, eop, thr, td;
    logic [2:0] cnt;
    logic [10:0] len;
    logic [127:0] d;
    logic e_rdy, e_v, e_sop, e_eop, e_err;
    logic [3:0] e_cnt;
    logic [10:0] e_len;
    logic [255:0] e_d;
  } vec_t;

  function automatic logic [31:0] dw(input int unsigned k);
    return 32'hC0DE_0000 + k;
  endfunction

  // n valid DW starting at index a; trailing slots carry junk that must not leak out
  function automatic logic [127:0] ibeat(input int unsigned a, input int unsigned n);
    logic [127:0] b;
    for (int unsigned j = 0; j < 4; j++) b[127-32*j -: 32] = (j < n) ? dw(a + j) : (32'hBAD0_0000 + j);
    return b;
  endfunction

  function automatic logic [255:0] obeat(input int unsigned a, input int unsigned n);
    logic [255:0] b;
    b = '0;
    for (int unsigned j = 0; j < n; j++) b[255-32*j -: 32] = dw(a + j);
    return b;
  endfunction

  function automatic vec_t mk(input logic v, sop, eop, thr, td, input logic [2:0] cnt,
                              input logic [10:0] len, input logic [127:0] d,
                              input logic rdy, ev, es, ee, er, input logic [3:0] ecnt,
                              input logic [10:0] elen, input logic [255:0] ed);
    vec_t x;
    x.v = v; x.sop = sop; x.eop = eop; x.thr = thr; x.td = td; x.cnt = cnt; x.len = len; x.d = d;
    x.e_rdy = rdy; x.e_v = ev; x.e_sop = es; x.e_eop = ee; x.e_err = er;
    x.e_cnt = ecnt; x.e_len = elen; x.e_d = ed;
    return x;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t x, input string nm);
    @(negedge clk);
    in_valid = x.v; in_sop = x.sop; in_eop = x.eop; dll_throttle = x.thr; in_td = x.td;
    in_dw_cnt = x.cnt; in_length = x.len; in_data = x.d;
    #1 chk({nm, "_rdy"}, 512'(in_ready), 512'(x.e_rdy));
    @(posedge clk);
    #1;
    if (x.e_v)
      chk({nm, "_out"}, 512'({out_valid, out_sop, out_eop, err_len, out_dw_cnt, out_length, out_data}),
          512'({1'b1, x.e_sop, x.e_eop, x.e_err, x.e_cnt, x.e_len, x.e_d}));
    else
      chk({nm, "_idle"}, 512'({out_valid, err_len}), 512'({1'b0, x.e_err}));
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; dll_throttle = 1'b0; in_td = 1'b0;
  endtask

  vec_t vt[$];
  logic [255:0] ex;

  initial begin
    // v sop eop thr td cnt len data | rdy ev es ee err ecnt elen edata
    vt.push_back(mk(1,1,0,0,0, 3'd4, 11'd7,  ibeat(0,4),  1,0,0,0,0, 4'd0, 11'd0,  '0));
    vt.push_back(mk(1,0,1,0,0, 3'd3, 11'd0,  ibeat(4,3),  1,1,1,1,0, 4'd7, 11'd7,  obeat(0,7)));
    vt.push_back(mk(0,0,0,0,0, 3'd0, 11'd0,  '0,          1,0,0,0,0, 4'd0, 11'd0,  '0));
    vt.push_back(mk(1,1,0,0,0, 3'd4, 11'd16, ibeat(16,4), 1,0,0,0,0, 4'd0, 11'd0,  '0));
    vt.push_back(mk(1,0,0,0,0, 3'd4, 11'd0,  ibeat(20,4), 1,1,1,0,0, 4'd8, 11'd16, obeat(16,8)));
    vt.push_back(mk(1,0,0,0,0, 3'd4, 11'd0,  ibeat(24,4), 1,0,0,0,0, 4'd0, 11'd0,  '0));
    vt.push_back(mk(1,0,1,0,0, 3'd4, 11'd0,  ibeat(28,4), 1,1,0,1,0, 4'd8, 11'd16, obeat(24,8)));
    vt.push_back(mk(1,1,1,0,0, 3'd3, 11'd3,  ibeat(40,3), 1,1,1,1,0, 4'd3, 11'd3,  obeat(40,3)));
    vt.push_back(mk(1,1,0,0,0, 3'd4, 11'd7,  ibeat(48,4), 1,0,0,0,0, 4'd0, 11'd0,  '0));
    vt.push_back(mk(1,0,1,0,0, 3'd2, 11'd0,  ibeat(52,2), 1,1,1,1,1, 4'd6, 11'd7,  obeat(48,6)));
    vt.push_back(mk(0,0,0,0,0, 3'd0, 11'd0,  '0,          1,0,0,0,0, 4'd0, 11'd0,  '0));
    vt.push_back(mk(1,1,0,0,0, 3'd4, 11'd4,  ibeat(56,4), 1,0,0,0,0, 4'd0, 11'd0,  '0));
    vt.push_back(mk(1,0,1,0,0, 3'd0, 11'd0,  ibeat(60,0), 1,1,1,1,1, 4'd4, 11'd4,  obeat(56,4)));
    vt.push_back(mk(1,1,1,1,0, 3'd4, 11'd4,  ibeat(64,4), 0,0,0,0,0, 4'd0, 11'd0,  '0));
    vt.push_back(mk(1,1,1,0,0, 3'd4, 11'd4,  ibeat(64,4), 1,1,1,1,0, 4'd4, 11'd4,  obeat(64,4)));
    vt.push_back(mk(1,1,0,0,0, 3'd4, 11'd8,  ibeat(72,4), 1,0,0,0,0, 4'd0, 11'd0,  '0));
    vt.push_back(mk(1,0,1,1,0, 3'd4, 11'd0,  ibeat(76,4), 1,1,1,1,0, 4'd8, 11'd8,  obeat(72,8)));

    repeat (2) @(posedge clk);
    #1 chk("reset_state", 512'({out_valid, out_sop, out_eop, err_len, in_ready, out_dw_cnt, out_data, out_length}), '0);
    @(negedge clk) arst = 1'b1;

    for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("vec%0d", i));

    // Halt for 3 cycles while a beat is presented on the output
    apply(mk(1,1,0,0,0, 3'd4, 11'd7, ibeat(96,4),  1,0,0,0,0, 4'd0, 11'd0, '0), "halt_pre0");
    apply(mk(1,0,1,0,0, 3'd3, 11'd0, ibeat(100,3), 1,1,1,1,0, 4'd7, 11'd7, obeat(96,7)), "halt_pre1");
    @(negedge clk);
    dll_halt = 1'b1;
    in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_dw_cnt = 3'd4; in_length = 11'd4; in_data = ibeat(112,4);
    for (int i = 0; i < 3; i++) begin
      #1 chk("halt_rdy", 512'(in_ready), 512'(1'b0));
      @(posedge clk);
      #1 chk("halt_hold", 512'({out_valid, out_sop, out_eop, out_dw_cnt, out_length, out_data}),
             512'({1'b1, 1'b1, 1'b1, 4'd7, 11'd7, obeat(96,7)}));
      @(negedge clk);
    end
    dll_halt = 1'b0;
    #1 chk("halt_release_rdy", 512'(in_ready), 512'(1'b1));
    @(posedge clk);
    #1 chk("halt_next", 512'({out_valid, out_sop, out_eop, out_dw_cnt, out_length, out_data}),
           512'({1'b1, 1'b1, 1'b1, 4'd4, 11'd4, obeat(112,4)}));
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    @(posedge clk);
    #1 chk("halt_no_dup", 512'(out_valid), 512'(1'b0));

    // Reset after the first beat of a 16-DW TLP
    apply(mk(1,1,0,0,0, 3'd4, 11'd16, ibeat(128,4), 1,0,0,0,0, 4'd0, 11'd0, '0), "rst_pre");
    @(negedge clk) arst = 1'b0;
    @(posedge clk);
    #1 chk("rst_mid", 512'({out_valid, out_sop, out_eop, err_len, in_ready, out_dw_cnt, out_data, out_length}), '0);
    @(negedge clk) arst = 1'b1;
    apply(mk(1,0,1,0,0, 3'd4, 11'd0, ibeat(132,4), 1,0,0,0,0, 4'd0, 11'd0, '0), "rst_stale");
    apply(mk(1,1,1,0,0, 3'd4, 11'd4, ibeat(140,4), 1,1,1,1,0, 4'd4, 11'd4, obeat(140,4)), "rst_new");
    apply(mk(0,0,0,0,0, 3'd0, 11'd0, '0,           1,0,0,0,0, 4'd0, 11'd0, '0), "rst_after");

`ifdef TLP_FRAG_ECRC_EN
    apply(mk(1,1,0,0,1, 3'd4, 11'd7, ibeat(160,4), 1,0,0,0,0, 4'd0, 11'd0, '0), "ecrc7_b0");
    apply(mk(1,0,1,0,1, 3'd3, 11'd0, ibeat(164,3), 1,0,0,0,0, 4'd0, 11'd0, '0), "ecrc7_b1");
    @(negedge clk);
    ecrc_valid = 1'b1; ecrc_dw = 32'hDEAD_BEEF;
    #1 chk("ecrc7_wait_rdy", 512'(in_ready), 512'(1'b0));
    @(posedge clk);
    ex = obeat(160,7);
    ex[31:0] = 32'hDEAD_BEEF;
    #1 chk("ecrc7_out", 512'({out_valid, out_sop, out_eop, out_dw_cnt, out_length, out_data}),
           512'({1'b1, 1'b1, 1'b1, 4'd8, 11'd8, ex}));
    ecrc_valid = 1'b0;

    apply(mk(1,1,0,0,1, 3'd4, 11'd8, ibeat(176,4), 1,0,0,0,0, 4'd0, 11'd0, '0), "ecrc8_b0");
    apply(mk(1,0,1,0,1, 3'd4, 11'd0, ibeat(180,4), 1,1,1,0,0, 4'd8, 11'd9, obeat(176,8)), "ecrc8_b1");
    @(negedge clk);
    ecrc_valid = 1'b1; ecrc_dw = 32'h1234_5678;
    @(posedge clk);
    ex = '0;
    ex[255:224] = 32'h1234_5678;
    #1 chk("ecrc8_out", 512'({out_valid, out_sop, out_eop, out_dw_cnt, out_length, out_data}),
           512'({1'b1, 1'b0, 1'b1, 4'd1, 11'd9, ex}));
    ecrc_valid = 1'b0;
`endif

    @(posedge clk);
    #1 chk("final_idle", 512'({out_valid, err_len}), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
